// File: rtl/vga_capture.sv
// vga_capture: samples a multi-bit VGA pixel stream, windows the active area,
// packs pixels into memory words and hands each word, with its {line, word}
// address, to the frame-buffer writer over a req/ack handshake.
//
// Handshake: wr_req rises the cycle after a word completes and holds, with
// d_out/a_out stable, until wr_ack is sampled high. A word that completes
// while a request is still pending is dropped and sets the sticky overflow flag.
module vga_capture #(
    parameter int PIX_BITS = 1,
    parameter int WORD_W   = 8,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int AH_W     = 7,
    parameter int AV_W     = 9,
    parameter int HC_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic [PIX_BITS-1:0]  video,
    input  logic                 enable,
    output logic                 wr_req,
    input  logic                 wr_ack,
    output logic [WORD_W-1:0]    d_out,
    output logic [AV_W+AH_W-1:0] a_out,
    output logic                 frame_start,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    localparam int PPW      = WORD_W / PIX_BITS;
    localparam int PC_W     = (PPW > 1) ? $clog2(PPW) : 1;
    // vcnt is just wide enough that its saturated value lies outside the active lines
    localparam int VC_W     = $clog2(V_START + V_ACTIVE + 1);
    localparam bit HAS_PART = (H_ACTIVE % PPW) != 0;

    localparam logic [HC_W-1:0] H_LO    = HC_W'(H_START);
    localparam logic [HC_W-1:0] H_HI    = HC_W'(H_START + H_ACTIVE);
    localparam logic [VC_W-1:0] V_LO    = VC_W'(V_START);
    localparam logic [VC_W-1:0] V_HI    = VC_W'(V_START + V_ACTIVE);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PPW - 1);

    generate
        if ((WORD_W % PIX_BITS) != 0) begin : g_bad_pix_bits
            $error("vga_capture: PIX_BITS must divide WORD_W");
        end
    endgenerate

    // sync chains hold active-high levels: [0]=s1, [1]=s2, [2]=s3 edge register
    logic [2:0]          r_hs_sync;
    logic [2:0]          r_vs_sync;
    logic [PIX_BITS-1:0] r_vid_d1;
    logic [PIX_BITS-1:0] r_vid_d2;
    logic [HC_W-1:0]     r_hcnt;
    logic [VC_W-1:0]     r_vcnt;
    logic                r_cap_en;
    logic                r_frame_start;
    logic [WORD_W-1:0]   r_shifter;
    logic [PC_W-1:0]     r_pcnt;
    logic [AH_W-1:0]     r_hword;
    logic                r_wr_req;
    logic [WORD_W-1:0]   r_d_out;
    logic [AV_W+AH_W-1:0] r_a_out;
    logic                r_overflow;

    logic                w_hs_edge;
    logic                w_vs_edge;
    logic                w_line_act;
    logic                w_pix_act;
    logic                w_full;
    logic                w_part;
    logic                w_complete;
    logic                w_slot_free;
    logic [VC_W-1:0]     w_vline;
    logic [WORD_W-1:0]   w_shifted;
    logic [WORD_W-1:0]   w_pad_word;
    logic [WORD_W-1:0]   w_word;

    assign w_hs_edge   = r_hs_sync[1] & ~r_hs_sync[2];
    assign w_vs_edge   = r_vs_sync[1] & ~r_vs_sync[2];
    assign w_line_act  = r_cap_en && (r_vcnt >= V_LO) && (r_vcnt < V_HI);
    assign w_pix_act   = w_line_act && !w_hs_edge && (r_hcnt >= H_LO) && (r_hcnt < H_HI);
    assign w_full      = w_pix_act && (r_pcnt == PC_LAST);
    // a line ending mid-word flushes the leftover pixels one clock after the last active pixel
    assign w_part      = HAS_PART && w_line_act && !w_hs_edge && (r_hcnt == H_HI) && (r_pcnt != '0);
    assign w_complete  = w_full | w_part;
    assign w_slot_free = !r_wr_req || wr_ack;
    assign w_vline     = r_vcnt - V_LO;
    assign w_shifted   = WORD_W'({r_shifter, r_vid_d2});
    // push the collected pixels up to the MSBs, leaving the empty slots as zeros
    assign w_pad_word  = r_shifter << (PIX_BITS * (PPW - int'(r_pcnt)));
    assign w_word      = w_full ? w_shifted : w_pad_word;

    // input synchronisers with polarity normalisation, video delayed to match s2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_sync <= '0;
            r_vs_sync <= '0;
            r_vid_d1  <= '0;
            r_vid_d2  <= '0;
        end else begin
            r_hs_sync <= {r_hs_sync[1:0], hsync == HS_POL};
            r_vs_sync <= {r_vs_sync[1:0], vsync == VS_POL};
            r_vid_d1  <= video;
            r_vid_d2  <= r_vid_d1;
        end
    end

    // saturating raster counters, frame-start pulse and per-frame capture enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt        <= '1;
            r_vcnt        <= '1;
            r_cap_en      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_vs_edge;
            if (w_hs_edge) begin
                r_hcnt <= '0;
            end else if (r_hcnt != '1) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
            if (w_vs_edge) begin
                r_vcnt   <= '0;
                r_cap_en <= enable;
            end else if (w_hs_edge && (r_vcnt != '1)) begin
                r_vcnt <= r_vcnt + 1'b1;
            end
        end
    end

    // pixel packing: first pixel of a word ends up in the MSBs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shifter <= '0;
            r_pcnt    <= '0;
            r_hword   <= '0;
        end else if (w_hs_edge) begin
            r_shifter <= '0;
            r_pcnt    <= '0;
            r_hword   <= '0;
        end else begin
            if (w_pix_act) begin
                r_shifter <= w_shifted;
            end
            if (w_complete) begin
                r_pcnt  <= '0;
                r_hword <= r_hword + 1'b1;
            end else if (w_pix_act) begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

    // writer handshake and sticky overflow (a new drop wins over clr_ovf)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_req   <= 1'b0;
            r_d_out    <= '0;
            r_a_out    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_complete && w_slot_free) begin
                r_wr_req <= 1'b1;
                r_d_out  <= w_word;
                r_a_out  <= {AV_W'(w_vline), r_hword};
            end else if (r_wr_req && wr_ack) begin
                r_wr_req <= 1'b0;
            end
            if (w_complete && !w_slot_free) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign wr_req      = r_wr_req;
    assign d_out       = r_d_out;
    assign a_out       = r_a_out;
    assign frame_start = r_frame_start;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: three instances share one raster stimulus.
//   dut_a: reference parameters, wr_ack driven by the bench
//   dut_p: H_ACTIVE=18 (partial last word), wr_ack tied high
//   dut_i: HS_POL/VS_POL=1 fed inverted syncs, wr_ack tied high
// A line is 40 clocks with hsync active for its first 3 clocks; pixel p is the
// video driven in clock 5+p of the line.
module tb_vga_capture;

    localparam int PB = 2;
    localparam int WW = 8;
    localparam int AH = 3;
    localparam int AV = 2;
    localparam int AW = AH + AV;
    localparam int EW = WW + AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, hs, vs, enable, ack_a, clr_ovf;
    logic [PB-1:0] video;
    logic          hs_n, vs_n;
    logic          req_a, req_p, req_i;
    logic [WW-1:0] d_a, d_p, d_i;
    logic [AW-1:0] a_a, a_p, a_i;
    logic          fs_a, fs_p, fs_i;
    logic          ovf_a, ovf_p, ovf_i;

    assign hs_n = ~hs;
    assign vs_n = ~vs;

    vga_capture #(.PIX_BITS(2), .WORD_W(8), .H_START(4), .H_ACTIVE(20), .V_START(2),
                  .V_ACTIVE(3), .HS_POL(1'b0), .VS_POL(1'b0), .AH_W(AH), .AV_W(AV), .HC_W(6))
    dut_a (.clk(clk), .rst_n(rst_n), .hsync(hs), .vsync(vs), .video(video), .enable(enable),
           .wr_req(req_a), .wr_ack(ack_a), .d_out(d_a), .a_out(a_a), .frame_start(fs_a),
           .overflow(ovf_a), .clr_ovf(clr_ovf));

    vga_capture #(.PIX_BITS(2), .WORD_W(8), .H_START(4), .H_ACTIVE(18), .V_START(2),
                  .V_ACTIVE(3), .HS_POL(1'b0), .VS_POL(1'b0), .AH_W(AH), .AV_W(AV), .HC_W(6))
    dut_p (.clk(clk), .rst_n(rst_n), .hsync(hs), .vsync(vs), .video(video), .enable(enable),
           .wr_req(req_p), .wr_ack(1'b1), .d_out(d_p), .a_out(a_p), .frame_start(fs_p),
           .overflow(ovf_p), .clr_ovf(clr_ovf));

    vga_capture #(.PIX_BITS(2), .WORD_W(8), .H_START(4), .H_ACTIVE(20), .V_START(2),
                  .V_ACTIVE(3), .HS_POL(1'b1), .VS_POL(1'b1), .AH_W(AH), .AV_W(AV), .HC_W(6))
    dut_i (.clk(clk), .rst_n(rst_n), .hsync(hs_n), .vsync(vs_n), .video(video), .enable(enable),
           .wr_req(req_i), .wr_ack(1'b1), .d_out(d_i), .a_out(a_i), .frame_start(fs_i),
           .overflow(ovf_i), .clr_ovf(clr_ovf));

    // scoreboard state
    logic [EW-1:0] exp_a[$];
    logic [EW-1:0] exp_p[$];
    logic [EW-1:0] exp_i[$];
    logic [PB-1:0] pix[20];
    int n_chk = 0;
    int n_err = 0;
    int words_a = 0;
    int fs_cnt_a = 0;
    int fs_cnt_p = 0;
    int fs_cnt_i = 0;
    int vcur = 7;
    bit cap_exp = 1'b0;
    bit use_mod4 = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // output monitors: a transfer is a cycle with wr_req and wr_ack both high
    always @(negedge clk) begin
        if (fs_a) fs_cnt_a++;
        if (req_a && ack_a) begin
            words_a++;
            check_eq("a_word_expected", exp_a.size() != 0, 1);
            if (exp_a.size() != 0) check_eq("a_word", {d_a, a_a}, exp_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (fs_p) fs_cnt_p++;
        if (req_p) begin
            check_eq("p_word_expected", exp_p.size() != 0, 1);
            if (exp_p.size() != 0) check_eq("p_word", {d_p, a_p}, exp_p.pop_front());
        end
    end

    always @(negedge clk) begin
        if (fs_i) fs_cnt_i++;
        if (req_i) begin
            check_eq("i_word_expected", exp_i.size() != 0, 1);
            if (exp_i.size() != 0) check_eq("i_word", {d_i, a_i}, exp_i.pop_front());
        end
    end

    // reference packing of the current line; a_mode 0: none, 1: all, 2: word 0 only
    task automatic push_words(input int line, input int a_mode);
        logic [WW-1:0] d;
        logic [EW-1:0] e;
        int ha;
        for (int hv = 0; hv < 2; hv++) begin
            ha = (hv == 1) ? 18 : 20;
            for (int w = 0; w * 4 < ha; w++) begin
                d = '0;
                for (int j = 0; j < 4; j++) begin
                    if (4 * w + j < ha) d[7 - 2 * j -: 2] = pix[4 * w + j];
                end
                e = {d, 2'(line), 3'(w)};
                if (hv == 1) begin
                    exp_p.push_back(e);
                end else begin
                    exp_i.push_back(e);
                    if (a_mode == 1 || (a_mode == 2 && w == 0)) exp_a.push_back(e);
                end
            end
        end
    endtask

    // one raster line; clr_seq exercises clr_ovf around the drops of words 0 and 1
    task automatic drive_line(input int a_mode, input bit clr_seq);
        bit act;
        vcur = (vcur < 7) ? vcur + 1 : 7;
        act = cap_exp && vcur >= 2 && vcur <= 4;
        for (int p = 0; p < 20; p++) pix[p] = use_mod4 ? 2'(p % 4) : 2'($urandom_range(0, 3));
        if (act) push_words(vcur - 2, a_mode);
        for (int k = 0; k < 40; k++) begin
            hs = (k >= 3);
            video = (k >= 5 && k < 25) ? pix[k - 5] : 2'($urandom_range(0, 3));
            if (clr_seq) clr_ovf = (k == 10 || k == 12);
            step();
            if (clr_seq) begin
                if (k == 10) check_eq("ovf_set_beats_clr", ovf_a, 1);
                if (k == 11) check_eq("ovf_sticky", ovf_a, 1);
                if (k == 12) check_eq("ovf_cleared", ovf_a, 0);
                if (k == 14) check_eq("ovf_set_by_drop", ovf_a, 1);
            end
        end
        clr_ovf = 1'b0;
    endtask

    task automatic drive_vsync();
        int fa = fs_cnt_a;
        int fp = fs_cnt_p;
        int fi = fs_cnt_i;
        hs = 1'b1;
        for (int k = 0; k < 8; k++) begin
            vs = (k >= 4);
            video = 2'($urandom_range(0, 3));
            step();
        end
        check_eq("frame_start_a", fs_cnt_a - fa, 1);
        check_eq("frame_start_p", fs_cnt_p - fp, 1);
        check_eq("frame_start_i", fs_cnt_i - fi, 1);
        vcur = 0;
        cap_exp = enable;
    endtask

    task automatic run_frame(input int a_first, input int a_rest, input int clr_line,
                             input int en_off_line, input int exp_words, input int exp_a_left);
        int w0 = words_a;
        drive_vsync();
        for (int l = 1; l <= 6; l++) begin
            if (l == en_off_line) enable = 1'b0;
            drive_line((l == 2) ? a_first : a_rest, l == clr_line);
        end
        repeat (4) step();
        check_eq("frame_words_a", words_a - w0, exp_words);
        check_eq("queue_a_left", exp_a.size(), exp_a_left);
        check_eq("queue_p_left", exp_p.size(), 0);
        check_eq("queue_i_left", exp_i.size(), 0);
    endtask

    initial begin
        int w0;
        rst_n = 1'b0; hs = 1'b1; vs = 1'b1; video = '0; enable = 1'b1;
        ack_a = 1'b1; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wr_req", req_a, 0);
        check_eq("rst_d_out", d_a, 0);
        check_eq("rst_a_out", a_a, 0);
        check_eq("rst_frame_start", fs_a, 0);
        check_eq("rst_overflow", ovf_a, 0);
        rst_n = 1'b1;
        step();

        // basic capture, video = pixel index mod 4
        run_frame(1, 1, 0, 0, 15, 0);
        check_eq("basic_no_overflow", ovf_a, 0);

        // backpressure on dut_a: only line 0 word 0 is ever held
        use_mod4 = 1'b0;
        ack_a = 1'b0;
        run_frame(2, 0, 3, 0, 0, 1);
        check_eq("bp_hold_req", req_a, 1);
        check_eq("bp_overflow", ovf_a, 1);
        check_eq("bp_held_word", {d_a, a_a}, exp_a[0]);
        ack_a = 1'b1;
        step();
        check_eq("bp_release_req", req_a, 0);
        check_eq("bp_release_queue", exp_a.size(), 0);
        check_eq("bp_ovf_sticky", ovf_a, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check_eq("bp_ovf_clear", ovf_a, 0);

        // enable dropped mid-frame, then a frame with capture off
        run_frame(1, 1, 0, 4, 15, 0);
        run_frame(1, 1, 0, 0, 0, 0);
        enable = 1'b1;

        // vcnt saturation: 600 lines without vsync produce nothing
        run_frame(1, 1, 0, 0, 15, 0);
        w0 = words_a;
        for (int l = 0; l < 600; l++) drive_line(1, 1'b0);
        check_eq("sat_no_words", words_a - w0, 0);
        check_eq("sat_no_overflow", ovf_a, 0);

        // asynchronous reset while a request is pending
        ack_a = 1'b0;
        run_frame(2, 0, 0, 0, 0, 1);
        check_eq("pre_reset_req", req_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_wr_req", req_a, 0);
        check_eq("async_rst_d_out", d_a, 0);
        check_eq("async_rst_a_out", a_a, 0);
        check_eq("async_rst_overflow", ovf_a, 0);
        check_eq("async_rst_frame_start", fs_a, 0);
        exp_a.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ack_a = 1'b1;
        vcur = 7;
        cap_exp = 1'b0;
        w0 = words_a;
        for (int l = 0; l < 6; l++) drive_line(1, 1'b0);
        check_eq("post_reset_idle", words_a - w0, 0);
        run_frame(1, 1, 0, 0, 15, 0);
        check_eq("final_ovf_p", ovf_p, 0);
        check_eq("final_ovf_i", ovf_i, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
